// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one 1-bit slice, LSB first, one bit per clock.
// Valid/ready on both sides; result held in DONE until taken.
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] sh_q;
  logic [WIDTH-1:0] sh_nxt;
  logic [2:0]       sel_q;
  logic             cy_q;
  logic             cy_nxt;
  logic             bit_o;
  logic [CW-1:0]    cnt_q;
  logic             last;

  logic ai, bi;
  logic is_add, is_sub, is_and, is_nor, is_xor;

  assign ai     = a_q[0];
  assign bi     = b_q[0];
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign sh_nxt = {bit_o, sh_q};

  assign is_add = (sel_q == 3'b000);
  assign is_sub = (sel_q == 3'b001);
  assign is_and = (sel_q == 3'b010);
  assign is_nor = (sel_q == 3'b011);
  assign is_xor = (sel_q == 3'b111);

  // single-bit slice: result bit and next carry/borrow
  always_comb begin
    bit_o  = 1'b0;
    cy_nxt = 1'b0;
    unique case (1'b1)
      is_add: begin
        bit_o  = ai ^ bi ^ cy_q;
        cy_nxt = (ai & bi) | (bi & cy_q) | (cy_q & ai);
      end
      is_sub: begin
        bit_o  = ai ^ bi ^ cy_q;
        cy_nxt = (~ai & bi) | (~(ai ^ bi) & cy_q);
      end
      is_and: bit_o = ai & bi;
      is_nor: bit_o = ~(ai | bi);
      is_xor: bit_o = ai ^ bi;
      default: begin
        bit_o  = 1'b0;
        cy_nxt = 1'b0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, serial shift and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      sh_q   <= '0;
      cy_q   <= 1'b0;
      cnt_q  <= '0;
      result <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sel_q <= sel;
            cy_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q  <= a_q >> 1;
          b_q  <= b_q >> 1;
          sh_q <= sh_nxt[WIDTH-1:1];
          cy_q <= cy_nxt;
          if (last) begin
            cnt_q  <= '0;
            result <= sh_nxt;
            c_out  <= cy_nxt;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
